cpu_trace_checker: RTL and testbench

- Streaming checker for CPU trace text, one ASCII character per clock.
- Parses register-write records `^<time>@<pc>: $<grf> <= <data>#` and memory-write records `^<time>@<pc>: *<addr> <= <data>#`.
- On each complete record it emits a one-cycle format/error result and updates saturating statistics counters.
- Parametrised successor of the fixed two-format checker: configurable field limits, address windows and counter width, plus `^` resynchronisation from any state.

---
 rtl/cpu_trace_pkg.sv | 40 ++++
 rtl/trace_char_class.sv | 21 ++
 rtl/cpu_trace_checker.sv | 222 ++++++++++++++++++++++
 tb/tb_cpu_trace_checker.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/cpu_trace_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// cpu_trace_pkg : parser states, ASCII codes, result codes and window check
// Rev 1.0
// ---------------------------------------------------------------------------
package cpu_trace_pkg;

  typedef enum logic [3:0] {
    S_IDLE, S_TIME, S_PC, S_COLON, S_SP1, S_GRF,
    S_ADDR, S_SP2, S_EQ, S_SP3, S_DATA, S_HASH
  } state_e;

  localparam logic [7:0] CH_CARET  = 8'h5e;
  localparam logic [7:0] CH_AT     = 8'h40;
  localparam logic [7:0] CH_COLON  = 8'h3a;
  localparam logic [7:0] CH_DOLLAR = 8'h24;
  localparam logic [7:0] CH_STAR   = 8'h2a;
  localparam logic [7:0] CH_LT     = 8'h3c;
  localparam logic [7:0] CH_EQ     = 8'h3d;
  localparam logic [7:0] CH_HASH   = 8'h23;
  localparam logic [7:0] CH_SPACE  = 8'h20;

  localparam logic [1:0] FMT_NONE = 2'b00;
  localparam logic [1:0] FMT_REG  = 2'b01;
  localparam logic [1:0] FMT_MEM  = 2'b10;

  localparam int ERR_TIME = 0;
  localparam int ERR_PC   = 1;
  localparam int ERR_ADDR = 2;
  localparam int ERR_GRF  = 3;

  // Single unsigned compare covers both window bounds; also flags word misalignment.
  function automatic logic outside_window(input logic [31:0] v,
                                          input logic [31:0] lo,
                                          input logic [31:0] hi);
    return ((v - lo) > (hi - lo)) || (v[1:0] != 2'b00);
  endfunction

endpackage
`default_nettype wire

// File: rtl/trace_char_class.sv
`default_nettype none
// ---------------------------------------------------------------------------
// trace_char_class : classifies one ASCII character as decimal / lowercase hex
// Rev 1.0
// ---------------------------------------------------------------------------
module trace_char_class (
  input  logic [7:0] char,
  output logic       is_dec,
  output logic       is_hex,
  output logic [3:0] nibble
);

  always_comb begin
    is_dec = (char >= 8'h30) && (char <= 8'h39);
    is_hex = is_dec || ((char >= 8'h61) && (char <= 8'h66));
    // 'a'..'f' have low nibbles 1..6, so adding 9 yields 10..15
    nibble = is_dec ? char[3:0] : (char[3:0] + 4'd9);
  end

endmodule
`default_nettype wire

// File: rtl/cpu_trace_checker.sv
`default_nettype none
// ---------------------------------------------------------------------------
// cpu_trace_checker : streaming parser/checker for register and memory trace records
// Rev 1.0
// ---------------------------------------------------------------------------
module cpu_trace_checker
  import cpu_trace_pkg::*;
#(
  parameter int unsigned TIME_DIG = 4,
  parameter int unsigned GRF_DIG  = 4,
  parameter int unsigned GRF_MAX  = 31,
  parameter logic [31:0] PC_LO    = 32'h0000_3000,
  parameter logic [31:0] PC_HI    = 32'h0000_4fff,
  parameter logic [31:0] ADDR_LO  = 32'h0000_0000,
  parameter logic [31:0] ADDR_HI  = 32'h0000_2fff,
  parameter int unsigned FREQ_W   = 16,
  parameter int unsigned CNT_W    = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        char,
  input  logic [FREQ_W-1:0] freq,
  output logic [1:0]        format_type,
  output logic [3:0]        error_code,
  output logic              msg_valid,
  output logic [CNT_W-1:0]  msg_count,
  output logic [CNT_W-1:0]  err_count
);

  localparam logic [3:0]  TIME_DIG_C = 4'(TIME_DIG);
  localparam logic [3:0]  GRF_DIG_C  = 4'(GRF_DIG);
  localparam logic [15:0] GRF_MAX_C  = 16'(GRF_MAX);

  state_e           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [31:0]      time_q, time_d;
  logic [31:0]      pc_q, pc_d;
  logic [31:0]      addr_q, addr_d;
  logic [15:0]      grf_q, grf_d;
  logic             mem_q, mem_d;
  logic [1:0]       fmt_q, fmt_d;
  logic [3:0]       err_q, err_d;
  logic             valid_q, valid_d;
  logic [CNT_W-1:0] msg_cnt_q, msg_cnt_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

  logic        commit;
  logic [3:0]  err_now;
  logic [31:0] freq_half;
  logic        is_dec, is_hex;
  logic [3:0]  nibble;

  trace_char_class u_class (
    .char   (char),
    .is_dec (is_dec),
    .is_hex (is_hex),
    .nibble (nibble)
  );

  // Record parser; data digits are only validated, their value is never needed.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    time_d  = time_q;
    pc_d    = pc_q;
    addr_d  = addr_q;
    grf_d   = grf_q;
    mem_d   = mem_q;
    commit  = 1'b0;
    if (char == CH_CARET) begin
      state_d = S_TIME;
      cnt_d   = '0;
      time_d  = '0;
      pc_d    = '0;
      addr_d  = '0;
      grf_d   = '0;
      mem_d   = 1'b0;
    end else begin
      // Unaccepted characters fall back to IDLE; every state entry restarts cnt.
      state_d = S_IDLE;
      cnt_d   = '0;
      case (state_q)
        S_TIME: begin
          if (is_dec && (cnt_q < TIME_DIG_C)) begin
            state_d = S_TIME;
            cnt_d   = cnt_q + 4'd1;
            time_d  = time_q * 32'd10 + {28'd0, nibble};
          end else if ((char == CH_AT) && (cnt_q != 4'd0)) begin
            state_d = S_PC;
          end
        end
        S_PC: begin
          if (is_hex) begin
            pc_d = {pc_q[27:0], nibble};
            if (cnt_q == 4'd7) begin
              state_d = S_COLON;
            end else begin
              state_d = S_PC;
              cnt_d   = cnt_q + 4'd1;
            end
          end
        end
        S_COLON: if (char == CH_COLON) state_d = S_SP1;
        S_SP1: begin
          if (char == CH_SPACE) begin
            state_d = S_SP1;
          end else if (char == CH_DOLLAR) begin
            state_d = S_GRF;
            mem_d   = 1'b0;
          end else if (char == CH_STAR) begin
            state_d = S_ADDR;
            mem_d   = 1'b1;
          end
        end
        S_GRF: begin
          if (is_dec && (cnt_q < GRF_DIG_C)) begin
            state_d = S_GRF;
            cnt_d   = cnt_q + 4'd1;
            grf_d   = grf_q * 16'd10 + {12'd0, nibble};
          end else if ((char == CH_SPACE) && (cnt_q != 4'd0)) begin
            state_d = S_SP2;
          end else if ((char == CH_LT) && (cnt_q != 4'd0)) begin
            state_d = S_EQ;
          end
        end
        S_ADDR: begin
          if (is_hex) begin
            addr_d = {addr_q[27:0], nibble};
            if (cnt_q == 4'd7) begin
              state_d = S_SP2;
            end else begin
              state_d = S_ADDR;
              cnt_d   = cnt_q + 4'd1;
            end
          end
        end
        S_SP2: begin
          if (char == CH_SPACE)   state_d = S_SP2;
          else if (char == CH_LT) state_d = S_EQ;
        end
        S_EQ: if (char == CH_EQ) state_d = S_SP3;
        S_SP3: begin
          if (char == CH_SPACE) begin
            state_d = S_SP3;
          end else if (is_hex) begin
            state_d = S_DATA;
            cnt_d   = 4'd1;
          end
        end
        S_DATA: begin
          if (is_hex) begin
            if (cnt_q == 4'd7) begin
              state_d = S_HASH;
            end else begin
              state_d = S_DATA;
              cnt_d   = cnt_q + 4'd1;
            end
          end
        end
        S_HASH: commit = (char == CH_HASH);
        default: ;
      endcase
    end
  end

  // Result evaluation from the registered fields; freq is a power of two.
  always_comb begin
    freq_half          = 32'(freq) >> 1;
    err_now            = 4'b0000;
    err_now[ERR_TIME]  = |((time_q << 1) & (freq_half - 32'd1));
    err_now[ERR_PC]    = outside_window(pc_q, PC_LO, PC_HI);
    err_now[ERR_ADDR]  = mem_q && outside_window(addr_q, ADDR_LO, ADDR_HI);
    err_now[ERR_GRF]   = !mem_q && (grf_q > GRF_MAX_C);

    fmt_d     = commit ? (mem_q ? FMT_MEM : FMT_REG) : FMT_NONE;
    err_d     = commit ? err_now : 4'b0000;
    valid_d   = commit;
    msg_cnt_d = msg_cnt_q;
    err_cnt_d = err_cnt_q;
    if (commit && (msg_cnt_q != {CNT_W{1'b1}})) msg_cnt_d = msg_cnt_q + 1'b1;
    if (commit && (err_now != 4'b0000) && (err_cnt_q != {CNT_W{1'b1}}))
      err_cnt_d = err_cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      time_q    <= '0;
      pc_q      <= '0;
      addr_q    <= '0;
      grf_q     <= '0;
      mem_q     <= 1'b0;
      fmt_q     <= FMT_NONE;
      err_q     <= '0;
      valid_q   <= 1'b0;
      msg_cnt_q <= '0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      time_q    <= time_d;
      pc_q      <= pc_d;
      addr_q    <= addr_d;
      grf_q     <= grf_d;
      mem_q     <= mem_d;
      fmt_q     <= fmt_d;
      err_q     <= err_d;
      valid_q   <= valid_d;
      msg_cnt_q <= msg_cnt_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign format_type = fmt_q;
  assign error_code  = err_q;
  assign msg_valid   = valid_q;
  assign msg_count   = msg_cnt_q;
  assign err_count   = err_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_cpu_trace_checker.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_cpu_trace_checker : directed and randomized record checks, two counter widths
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_cpu_trace_checker;

  logic        clk;
  logic        reset;
  logic [7:0]  char;
  logic [15:0] freq;

  logic [1:0]  format_type,  format_type2;
  logic [3:0]  error_code,   error_code2;
  logic        msg_valid,    msg_valid2;
  logic [15:0] msg_count,    err_count;
  logic [1:0]  msg_count2,   err_count2;

  int n_cmp  = 0;
  int n_fail = 0;
  int n_msgs = 0;
  int n_errs = 0;

  cpu_trace_checker u_dut (
    .clk         (clk),
    .reset       (reset),
    .char        (char),
    .freq        (freq),
    .format_type (format_type),
    .error_code  (error_code),
    .msg_valid   (msg_valid),
    .msg_count   (msg_count),
    .err_count   (err_count)
  );

  cpu_trace_checker #(.CNT_W(2)) u_dut_narrow (
    .clk         (clk),
    .reset       (reset),
    .char        (char),
    .freq        (freq),
    .format_type (format_type2),
    .error_code  (error_code2),
    .msg_valid   (msg_valid2),
    .msg_count   (msg_count2),
    .err_count   (err_count2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int sat(input int n, input int mx);
    return (n > mx) ? mx : n;
  endfunction

  function automatic string spaces(input int n);
    string r = "";
    for (int i = 0; i < n; i++) r = {r, " "};
    return r;
  endfunction

  task automatic send_char(input logic [7:0] c);
    char = c;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    char  = 8'h00;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset  = 1'b0;
    n_msgs = 0;
    n_errs = 0;
  endtask

  task automatic check_counts(input string tag);
    check({tag, " msg_count"},  32'(msg_count),  32'(sat(n_msgs, 65535)));
    check({tag, " err_count"},  32'(err_count),  32'(sat(n_errs, 65535)));
    check({tag, " msg_count2"}, 32'(msg_count2), 32'(sat(n_msgs, 3)));
    check({tag, " err_count2"}, 32'(err_count2), 32'(sat(n_errs, 3)));
  endtask

  // Feed a string, count pulses, then verify results, counters and pulse width.
  task automatic send_rec(input string s, input int exp_p, input logic [1:0] ef,
                          input logic [3:0] ee, input int exp_e);
    int         p1 = 0;
    int         p2 = 0;
    logic [1:0] cf = 2'b00;
    logic [3:0] ce = 4'b0000;
    for (int i = 0; i < s.len(); i++) begin
      send_char(s[i]);
      if (msg_valid) begin
        p1++;
        cf = format_type;
        ce = error_code;
      end
      if (msg_valid2) p2++;
    end
    n_msgs += exp_p;
    n_errs += exp_e;
    check({s, " pulses"},  32'(p1), 32'(exp_p));
    check({s, " pulses2"}, 32'(p2), 32'(exp_p));
    if (exp_p > 0) begin
      check({s, " format_type"}, 32'(cf), 32'(ef));
      check({s, " error_code"},  32'(ce), 32'(ee));
    end
    check_counts(s);
    send_char("z");
    check({s, " valid_after"},  32'(msg_valid),   32'd0);
    check({s, " format_after"}, 32'(format_type), 32'd0);
  endtask

  // Random record built from fields; expectations come from the field rules.
  task automatic gen_rec(input int unsigned f, output string s, output int np,
                         output logic [1:0] fmt, output logic [3:0] err);
    int unsigned t, pc, addr, grf, data, bad;
    bit          mem;
    string       tstr, pcstr, fstr, dstr, lt;
    t    = $urandom_range(0, 9999);
    pc   = ($urandom_range(0, 3) == 0) ? $urandom : $urandom_range(32'h2ff0, 32'h5010);
    addr = ($urandom_range(0, 3) == 0) ? $urandom : $urandom_range(0, 32'h3010);
    grf  = $urandom_range(0, 40);
    data = $urandom;
    mem  = 1'($urandom_range(0, 1));
    bad  = $urandom_range(0, 9);
    tstr  = (bad == 0) ? $sformatf("%0d", t + 10000) : $sformatf("%0d", t);
    pcstr = (bad == 1) ? {$sformatf("%07h", pc >> 4), "A"} : $sformatf("%08h", pc);
    dstr  = (bad == 2) ? $sformatf("%07h", data >> 4) : $sformatf("%08h", data);
    lt    = (bad == 3) ? "< =" : "<=";
    fstr  = mem ? {"*", $sformatf("%08h", addr)} : {"$", $sformatf("%0d", grf)};
    s = {"^", tstr, "@", pcstr, ":", spaces($urandom_range(0, 2)), fstr,
         spaces($urandom_range(0, 2)), lt, spaces($urandom_range(0, 2)), dstr, "#"};
    np     = (bad <= 3) ? 0 : 1;
    fmt    = mem ? 2'b10 : 2'b01;
    err[0] = ((2 * t) % (f / 2)) != 0;
    err[1] = (pc < 32'h3000) || (pc > 32'h4fff) || ((pc % 4) != 0);
    err[2] = mem && ((addr > 32'h2fff) || ((addr % 4) != 0));
    err[3] = !mem && (grf > 31);
  endtask

  initial begin
    string       s;
    int          np;
    logic [1:0]  fmt;
    logic [3:0]  err;
    int unsigned f;

    reset = 1'b1;
    char  = 8'h00;
    freq  = 16'd4;
    do_reset();

    check("reset format_type", 32'(format_type), 32'd0);
    check("reset error_code",  32'(error_code),  32'd0);
    check("reset msg_valid",   32'(msg_valid),   32'd0);
    check_counts("reset");

    // Reset mid-record discards the record
    s = "^1@00003000: $1<=0000000";
    for (int i = 0; i < s.len(); i++) send_char(s[i]);
    do_reset();
    send_rec("#", 0, 2'b00, 4'b0000, 0);

    freq = 16'd4;
    send_rec("^10@00003010: $1 <= 0000abcd#", 1, 2'b01, 4'b0000, 0);
    freq = 16'd8;
    send_rec("^3@00002ffc:*00000006<=12345678#", 1, 2'b10, 4'b0111, 1);
    freq = 16'd2;
    send_rec("^0@00003000: $32<=ffffffff#", 1, 2'b01, 4'b1000, 1);
    send_rec("^0@00004fff: $0<=00000000#", 1, 2'b01, 4'b0010, 1);
    freq = 16'd4;
    send_rec("^12@0003^5@00003000: $0<=00000000#", 1, 2'b01, 4'b0000, 0);
    send_rec("^12345@00003000: $1<=00000000#", 0, 2'b00, 4'b0000, 0);
    send_rec("^1@0000300A: $1<=00000000#", 0, 2'b00, 4'b0000, 0);
    send_rec("^1@00003000: $1<=0000ABCD#", 0, 2'b00, 4'b0000, 0);
    freq = 16'd2;
    send_rec("^0@00003000: $1<=00000000#^0@00003004:*00000010<=00000000#",
             2, 2'b10, 4'b0000, 0);

    // Saturation of the narrow counters
    do_reset();
    for (int k = 0; k < 5; k++)
      send_rec("^0@00002000: $1<=00000000#", 1, 2'b01, 4'b0010, 1);

    do_reset();
    for (int k = 0; k < 80; k++) begin
      f    = 32'd1 << $urandom_range(1, 15);
      freq = 16'(f);
      gen_rec(f, s, np, fmt, err);
      send_rec(s, np, fmt, err, (np == 1 && err != 4'b0000) ? 1 : 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
